// File: rtl/wb_decoder_if.sv
// Wishbone bundle between the upstream master port, the address decoder and its four slaves.
interface wb_decoder_if;
  logic [31:0]  m_adr_i;
  logic [31:0]  m_dat_i;
  logic [31:0]  m_dat_o;
  logic         m_we_i;
  logic [3:0]   m_sel_i;
  logic         m_stb_i;
  logic         m_cyc_i;
  logic         m_ack_o;
  logic [31:0]  s_adr_o;
  logic [31:0]  s_dat_o;
  logic         s_we_o;
  logic [3:0]   s_sel_o;
  logic [3:0]   s_stb_o;
  logic [3:0]   s_cyc_o;
  logic [127:0] s_dat_i;
  logic [3:0]   s_ack_i;
  logic         timeout_o;
  logic [31:0]  err_adr_o;

  // Decoder view: takes requests from upstream and slave responses.
  modport slave (
    input  m_adr_i, m_dat_i, m_we_i, m_sel_i, m_stb_i, m_cyc_i, s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o,
           timeout_o, err_adr_o
  );

  // Environment view: upstream master plus the four downstream slaves.
  modport master (
    output m_adr_i, m_dat_i, m_we_i, m_sel_i, m_stb_i, m_cyc_i, s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o,
           timeout_o, err_adr_o
  );
endinterface

// File: rtl/wb_decoder.sv
// Single-initiator Wishbone decoder: routes one access to one of four slaves by adr[31:28],
// returns registered data/ack, and forces an error completion on unmapped or stalled accesses.
module wb_decoder #(
  parameter logic [3:0]  S0_BASE  = 4'h0,
  parameter logic [3:0]  S1_BASE  = 4'h1,
  parameter logic [3:0]  S2_BASE  = 4'h2,
  parameter logic [3:0]  S3_BASE  = 4'h8,
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input logic         clk,
  input logic         rst,
  wb_decoder_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP, HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [3:0]       stb;

  logic        hit_c;
  logic [1:0]  hit_idx_c;
  logic [31:0] sel_dat_c;
  logic        sel_ack_c;

  // Priority address match: the lowest slave index wins when bases collide.
  always_comb begin
    hit_c     = 1'b1;
    hit_idx_c = 2'd0;
    if      (bus.m_adr_i[31:28] == S0_BASE) hit_idx_c = 2'd0;
    else if (bus.m_adr_i[31:28] == S1_BASE) hit_idx_c = 2'd1;
    else if (bus.m_adr_i[31:28] == S2_BASE) hit_idx_c = 2'd2;
    else if (bus.m_adr_i[31:28] == S3_BASE) hit_idx_c = 2'd3;
    else                                    hit_c     = 1'b0;
  end

  assign sel_dat_c   = bus.s_dat_i[{idx, 5'd0} +: 32];
  assign sel_ack_c   = bus.s_ack_i[idx];
  assign bus.s_stb_o = stb;
  assign bus.s_cyc_o = stb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      stb           <= '0;
      bus.m_dat_o   <= '0;
      bus.m_ack_o   <= 1'b0;
      bus.s_adr_o   <= '0;
      bus.s_dat_o   <= '0;
      bus.s_we_o    <= 1'b0;
      bus.s_sel_o   <= '0;
      bus.timeout_o <= 1'b0;
      bus.err_adr_o <= '0;
    end else begin
      bus.m_ack_o   <= 1'b0;
      bus.timeout_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.m_cyc_i && bus.m_stb_i) begin
            bus.s_adr_o <= bus.m_adr_i;
            bus.s_dat_o <= bus.m_dat_i;
            bus.s_we_o  <= bus.m_we_i;
            bus.s_sel_o <= bus.m_sel_i;
            if (hit_c) begin
              idx   <= hit_idx_c;
              stb   <= 4'b0001 << hit_idx_c;
              cnt   <= '0;
              state <= ACTIVE;
            end else begin
              bus.m_dat_o   <= ERR_DATA;
              bus.m_ack_o   <= 1'b1;
              bus.err_adr_o <= bus.m_adr_i;
              state         <= RESP;
            end
          end
        end
        ACTIVE: begin
          if (!bus.m_cyc_i) begin
            stb   <= '0;
            state <= IDLE;
          end else if (sel_ack_c) begin
            // A slave ack on the last allowed cycle still counts as a normal completion.
            bus.m_dat_o <= sel_dat_c;
            bus.m_ack_o <= 1'b1;
            stb         <= '0;
            state       <= RESP;
          end else if (cnt == CNT_LAST) begin
            bus.m_dat_o   <= ERR_DATA;
            bus.m_ack_o   <= 1'b1;
            bus.timeout_o <= 1'b1;
            bus.err_adr_o <= bus.s_adr_o;
            stb           <= '0;
            state         <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: state <= HOLD;
        // Wait out the master's lingering strobe so it cannot start a second access.
        HOLD: if (!bus.m_stb_i || !bus.m_cyc_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_decoder.sv
// Self-checking bench for wb_decoder: directed scenarios then randomized transactions,
// each predicted from a transaction-level model of decode, latency and error rules.
module tb_wb_decoder;
  localparam int unsigned TIMEOUT  = 16;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
  localparam logic [3:0]  BASES [4] = '{4'h0, 4'h1, 4'h2, 4'h8};

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] exp_dat;
  logic [31:0] exp_err;

  wb_decoder_if bus ();

  wb_decoder #(
    .S0_BASE(4'h0), .S1_BASE(4'h1), .S2_BASE(4'h2), .S3_BASE(4'h8),
    .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int decode(input logic [3:0] nib);
    for (int i = 0; i < 4; i++) if (nib == BASES[i]) return i;
    return -1;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, ".m_dat_o"},   bus.m_dat_o,   32'h0);
    chk({tag, ".m_ack_o"},   bus.m_ack_o,   32'h0);
    chk({tag, ".s_adr_o"},   bus.s_adr_o,   32'h0);
    chk({tag, ".s_dat_o"},   bus.s_dat_o,   32'h0);
    chk({tag, ".s_we_o"},    bus.s_we_o,    32'h0);
    chk({tag, ".s_sel_o"},   bus.s_sel_o,   32'h0);
    chk({tag, ".s_stb_o"},   bus.s_stb_o,   32'h0);
    chk({tag, ".s_cyc_o"},   bus.s_cyc_o,   32'h0);
    chk({tag, ".timeout_o"}, bus.timeout_o, 32'h0);
    chk({tag, ".err_adr_o"}, bus.err_adr_o, 32'h0);
  endtask

  task automatic rand_slaves(input logic [3:0] keep_off);
    bus.s_dat_i = {$urandom, $urandom, $urandom, $urandom};
    bus.s_ack_i = 4'($urandom) & ~keep_off;
  endtask

  // One request issued in cycle 0. ack_k: cycle the selected slave acks (0 = never).
  // linger: cycles the master keeps stb up after the ack. abort_c: cycle cyc is dropped (0 = none).
  task automatic run_txn(input logic [31:0] adr, input logic [31:0] wdat, input logic we,
                         input logic [3:0] sel, input int ack_k, input logic [31:0] ack_dat,
                         input int linger, input int abort_c);
    int idx, done, end_c;
    bit mapped, to, aborted;
    logic [3:0] oh, exp_stb;
    idx     = decode(adr[31:28]);
    mapped  = (idx >= 0);
    oh      = mapped ? 4'(1 << idx) : 4'b0;
    to      = mapped && !(ack_k >= 1 && ack_k <= int'(TIMEOUT));
    done    = !mapped ? 1 : (to ? int'(TIMEOUT) + 1 : ack_k + 1);
    aborted = mapped && abort_c > 0 && abort_c < done;
    end_c   = aborted ? abort_c + 1 : done;

    bus.m_adr_i = adr;
    bus.m_dat_i = wdat;
    bus.m_we_i  = we;
    bus.m_sel_i = sel;
    bus.m_cyc_i = 1'b1;
    bus.m_stb_i = 1'b1;
    rand_slaves(oh);
    for (int c = 1; c <= end_c; c++) begin
      step();
      if (c == done && !aborted) begin
        exp_dat = (to || !mapped) ? ERR_DATA : ack_dat;
        if (to || !mapped) exp_err = adr;
      end
      exp_stb = (mapped && c < end_c) ? oh : 4'b0;
      chk("s_stb_o",   bus.s_stb_o,   exp_stb);
      chk("s_cyc_o",   bus.s_cyc_o,   exp_stb);
      chk("m_ack_o",   bus.m_ack_o,   32'(c == done && !aborted));
      chk("timeout_o", bus.timeout_o, 32'(c == done && !aborted && to));
      chk("m_dat_o",   bus.m_dat_o,   exp_dat);
      chk("err_adr_o", bus.err_adr_o, exp_err);
      if (c == 1) begin
        chk("s_adr_o", bus.s_adr_o, adr);
        chk("s_dat_o", bus.s_dat_o, wdat);
        chk("s_we_o",  bus.s_we_o,  32'(we));
        chk("s_sel_o", bus.s_sel_o, 32'(sel));
      end
      rand_slaves(oh);
      if (mapped && c == ack_k && c < done && !(aborted && c >= abort_c)) begin
        bus.s_ack_i = bus.s_ack_i | oh;
        bus.s_dat_i[idx*32 +: 32] = ack_dat;
      end
      if (c >= done) bus.s_ack_i = 4'b0;
      if (aborted && c == abort_c) begin
        bus.m_cyc_i = 1'b0;
        bus.m_stb_i = 1'b0;
      end
      if (!aborted && c == done) bus.m_stb_i = (linger > 0);
    end
    bus.s_ack_i = 4'b0;
    if (!aborted) begin
      for (int j = 1; j <= linger; j++) begin
        step();
        chk("hold_stb", bus.s_stb_o, 32'h0);
        chk("hold_ack", bus.m_ack_o, 32'h0);
        bus.m_stb_i = (j < linger);
      end
      bus.m_cyc_i = 1'b0;
      for (int j = 0; j < 2; j++) begin
        step();
        chk("release_stb", bus.s_stb_o, 32'h0);
        chk("release_ack", bus.m_ack_o, 32'h0);
        chk("release_dat", bus.m_dat_o, exp_dat);
      end
    end
  endtask

  initial begin
    logic [3:0] nib;
    int ack_k, linger, abort_c;
    rst         = 1'b1;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.m_we_i  = 1'b0;
    bus.m_sel_i = '0;
    bus.m_cyc_i = 1'b0;
    bus.m_stb_i = 1'b0;
    bus.s_dat_i = '0;
    bus.s_ack_i = '0;
    exp_dat     = '0;
    exp_err     = '0;
    step();
    step();
    chk_zero("reset");
    rst = 1'b0;
    step();

    run_txn(32'h1000_0010, 32'h0,          1'b0, 4'hF,    2,       32'hA5A5_0001, 0, 0);
    run_txn(32'h0000_0100, 32'h1234_5678,  1'b1, 4'b0011, 3,       32'h0BAD_F00D, 0, 0);
    run_txn(32'hF000_0000, 32'h0,          1'b0, 4'hF,    0,       32'h0,         0, 0);
    run_txn(32'h8000_0004, 32'h0,          1'b0, 4'hF,    0,       32'h0,         0, 0);
    run_txn(32'h2000_0040, 32'h0,          1'b0, 4'hF,    TIMEOUT, 32'hC0DE_0002, 0, 0);
    run_txn(32'h1000_0000, 32'h0,          1'b0, 4'hF,    1,       32'h1111_2222, 2, 0);
    run_txn(32'h1000_0020, 32'h0,          1'b0, 4'hF,    0,       32'h0,         0, 3);

    // Reset while a slave strobe is outstanding.
    bus.m_adr_i = 32'h8000_0004;
    bus.m_cyc_i = 1'b1;
    bus.m_stb_i = 1'b1;
    bus.s_ack_i = 4'b0;
    step();
    chk("rst_pre_stb", bus.s_stb_o, 32'h8);
    step();
    step();
    rst = 1'b1;
    step();
    chk_zero("rst_mid");
    rst         = 1'b0;
    bus.m_cyc_i = 1'b0;
    bus.m_stb_i = 1'b0;
    exp_dat     = '0;
    exp_err     = '0;
    step();

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0:       nib = 4'h0;
        1:       nib = 4'h1;
        2:       nib = 4'h2;
        3:       nib = 4'h8;
        default: nib = 4'($urandom);
      endcase
      case ($urandom_range(0, 9))
        0:       ack_k = 0;
        1:       ack_k = TIMEOUT;
        default: ack_k = $urandom_range(1, 6);
      endcase
      linger  = $urandom_range(0, 3);
      abort_c = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 5) : 0;
      run_txn({nib, 28'($urandom)}, $urandom, 1'($urandom), 4'($urandom),
              ack_k, $urandom, linger, abort_c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
